// File: rtl/xdma_stream_arbiter_pkg.sv
// Shared definitions for the XDMA C2H stream arbiter and the stream packers.
// Holds the arbiter state encoding, the round-robin pick helper and the
// default AXI-Stream widths.
package xdma_arb_pkg;

  localparam int AXIS_DATA_WIDTH_DEF = 512;
  localparam int KEEP_WIDTH_DEF      = AXIS_DATA_WIDTH_DEF / 8;
  localparam int MAX_SRC             = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // First set bit of req searching upward from last+1, modulo n.
  // Scans from the farthest candidate back to the nearest so the nearest wins.
  function automatic int rr_pick(input logic [MAX_SRC-1:0] req, input int last, input int n);
    int         pick;
    logic [2:0] idx;
    pick = 0;
    for (int k = MAX_SRC; k >= 1; k--) begin
      if (k <= n) begin
        idx = 3'((last + k) % n);
        if (req[idx]) pick = 32'(idx);
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/xdma_stream_arbiter_if.sv
// Source-side and XDMA-side AXI-Stream bundle of the arbiter.
// slave: the arbiter's view; master: the view of whoever drives the sources
// and sinks the output stream.
interface xdma_stream_arbiter_if import xdma_arb_pkg::*; #(
  parameter int N_SRC           = 2,
  parameter int AXIS_DATA_WIDTH = AXIS_DATA_WIDTH_DEF,
  parameter int KEEP_WIDTH      = AXIS_DATA_WIDTH / 8
);
  localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC*AXIS_DATA_WIDTH-1:0] s_tdata;
  logic [N_SRC*KEEP_WIDTH-1:0]      s_tkeep;
  logic [N_SRC-1:0]                 s_tlast;
  logic [N_SRC-1:0]                 s_tvalid;
  logic [N_SRC-1:0]                 s_tready;
  logic [AXIS_DATA_WIDTH-1:0]       m_tdata;
  logic [KEEP_WIDTH-1:0]            m_tkeep;
  logic                             m_tlast;
  logic [SRC_W-1:0]                 m_tid;
  logic                             m_tvalid;
  logic                             m_tready;

  modport slave (
    input  s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
    output s_tready, m_tdata, m_tkeep, m_tlast, m_tid, m_tvalid
  );

  modport master (
    output s_tdata, s_tkeep, s_tlast, s_tvalid, m_tready,
    input  s_tready, m_tdata, m_tkeep, m_tlast, m_tid, m_tvalid
  );
endinterface

// File: rtl/xdma_axis_reg_slice.sv
// One-entry AXI-Stream output register. Accepts a beat whenever it is empty
// or being drained in the same cycle, so it sustains one beat per cycle.
module xdma_axis_reg_slice #(
  parameter int DW  = 512,
  parameter int KW  = DW / 8,
  parameter int IDW = 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DW-1:0]  in_data,
  input  logic [KW-1:0]  in_keep,
  input  logic           in_last,
  input  logic [IDW-1:0] in_id,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DW-1:0]  out_data,
  output logic [KW-1:0]  out_keep,
  output logic           out_last,
  output logic [IDW-1:0] out_id
);

  assign in_ready = !out_valid || out_ready;

  // Load on input handshake, otherwise empty once the consumer takes the beat.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
      out_id    <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_keep  <= in_keep;
      out_last  <= in_last;
      out_id    <= in_id;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/xdma_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing the XDMA C2H AXI-Stream between
// N_SRC packet sources. A granted source owns the stream until its tlast beat
// is accepted; beats go out through one register stage tagged with m_tid.
// Optional per-source packet/beat counters: define XDMA_ARB_STATS_EN.
module xdma_stream_arbiter import xdma_arb_pkg::*; #(
  parameter int N_SRC           = 2,
  parameter int AXIS_DATA_WIDTH = AXIS_DATA_WIDTH_DEF,
  parameter int KEEP_WIDTH      = AXIS_DATA_WIDTH / 8,
  parameter int SRC_W           = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_SRC-1:0]        src_enable,
  xdma_stream_arbiter_if.slave    axis,
  output logic                    busy
`ifdef XDMA_ARB_STATS_EN
  ,
  output logic [N_SRC*32-1:0]     stat_pkt_cnt,
  output logic [N_SRC*32-1:0]     stat_beat_cnt
`endif
);

  arb_state_e                 state;
  logic [SRC_W-1:0]           grant;
  logic [SRC_W-1:0]           last_grant;
  logic [N_SRC-1:0]           req;
  logic [N_SRC-1:0]           s_rdy;
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_last;
  logic                       hs;
  logic [AXIS_DATA_WIDTH-1:0] in_data;
  logic [KEEP_WIDTH-1:0]      in_keep;

  assign req      = axis.s_tvalid & src_enable;
  assign busy     = (state == ARB_BUSY);
  assign in_valid = busy && axis.s_tvalid[grant];
  assign in_last  = axis.s_tlast[grant];
  assign in_data  = axis.s_tdata[int'(grant)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
  assign in_keep  = axis.s_tkeep[int'(grant)*KEEP_WIDTH +: KEEP_WIDTH];
  assign hs       = in_valid && in_ready;
  assign axis.s_tready = s_rdy;

  // Only the owner sees ready, and only while the output stage can take a beat.
  always_comb begin
    s_rdy = '0;
    if (busy) s_rdy[grant] = in_ready;
  end

  // Arbitrate in IDLE, hold the grant in BUSY until the owner's tlast is taken.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      grant      <= '0;
      last_grant <= SRC_W'(N_SRC - 1);
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req) begin
            grant <= SRC_W'(rr_pick(MAX_SRC'(req), int'(last_grant), N_SRC));
            state <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (hs && in_last) begin
            state      <= ARB_IDLE;
            last_grant <= grant;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  xdma_axis_reg_slice #(
    .DW  (AXIS_DATA_WIDTH),
    .KW  (KEEP_WIDTH),
    .IDW (SRC_W)
  ) u_oreg (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_last   (in_last),
    .in_id     (grant),
    .out_valid (axis.m_tvalid),
    .out_ready (axis.m_tready),
    .out_data  (axis.m_tdata),
    .out_keep  (axis.m_tkeep),
    .out_last  (axis.m_tlast),
    .out_id    (axis.m_tid)
  );

`ifdef XDMA_ARB_STATS_EN
  logic [N_SRC-1:0] acc;
  assign acc = axis.s_tvalid & s_rdy;

  for (genvar i = 0; i < N_SRC; i++) begin : g_stat
    logic [31:0] pkt_q;
    logic [31:0] beat_q;

    // Free-running wrap-around counters of accepted beats and packets.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        pkt_q  <= '0;
        beat_q <= '0;
      end else if (acc[i]) begin
        beat_q <= beat_q + 32'd1;
        if (axis.s_tlast[i]) pkt_q <= pkt_q + 32'd1;
      end
    end

    assign stat_pkt_cnt[i*32 +: 32]  = pkt_q;
    assign stat_beat_cnt[i*32 +: 32] = beat_q;
  end
`endif

endmodule

// File: doc/xdma_stream_arbiter.md
Name: xdma_stream_arbiter

Overview:
- Packet-granular round-robin arbiter sharing the single XDMA C2H AXI-Stream between several packet sources.
- Typical sources: the difftest batch packer, a log/print channel and a status channel.
- Sits between the per-source stream packers and the XDMA IP.
- Once a source is granted, it owns the stream until its tlast beat is accepted. Beats are forwarded through one registered output stage, with the source index tagged on m_tid.

Parameters:
- N_SRC, 2, number of requesting sources (2..8).
- AXIS_DATA_WIDTH, 512, tdata width per source and on the output.
- KEEP_WIDTH, AXIS_DATA_WIDTH/8, tkeep width.
- SRC_W, $clog2(N_SRC) (minimum 1), width of m_tid and the grant index.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- src_enable  in  N_SRC  per-source arbitration mask; sampled only at arbitration.
- s_tdata  in  N_SRC*AXIS_DATA_WIDTH  packed source data; source i occupies bits [i*W +: W].
- s_tkeep  in  N_SRC*KEEP_WIDTH  packed byte enables.
- s_tlast  in  N_SRC  per-source end of packet.
- s_tvalid  in  N_SRC  per-source beat valid.
- s_tready  out  N_SRC  per-source ready.
- m_tdata  out  AXIS_DATA_WIDTH  output data.
- m_tkeep  out  KEEP_WIDTH  output byte enables.
- m_tlast  out  1  output end of packet.
- m_tid  out  SRC_W  index of the source that owns the current beat.
- m_tvalid  out  1  output valid.
- m_tready  in  1  XDMA ready.
- busy  out  1  high while a packet is granted (state BUSY).

Behaviour:
- Reset (asynchronous assert, synchronous-release use): state=IDLE; m_tvalid=0; m_tlast=0; m_tdata=0; m_tkeep=0; m_tid=0; s_tready=0; busy=0; last_grant=N_SRC-1, so source 0 wins first. Reset mid-packet drops the partial packet; no recovery.
- State machine, two states:
  - IDLE: req = s_tvalid & src_enable. If req≠0, grant = first set bit searching upward from last_grant+1, modulo N_SRC; register grant; next state BUSY. If req=0, stay in IDLE.
  - BUSY: s_tready[grant] = !m_tvalid | m_tready; all other s_tready bits are 0.
    - On each s_tvalid[grant] & s_tready[grant], load the output register with {data, keep, last, tid=grant} and set m_tvalid=1.
    - If the accepted beat has tlast=1, next state is IDLE and last_grant<=grant.
- Output register:
  - m_tvalid clears on m_tready with no new load.
  - A simultaneous drain and load keeps m_tvalid=1.
  - Latency is 1 cycle from input handshake to m_tvalid. Full throughput is 1 beat/cycle within a packet.
- Inter-packet gap: one input-side bubble cycle (the IDLE arbitration cycle). The output side may still be draining during it.
- Boundary conditions:
  - Granted source drops s_tvalid mid-packet: the grant is held; a bubble appears on the output; no other source is served.
  - src_enable deasserted for the granted source mid-packet: no effect until its tlast.
  - Single-beat packet (tlast on the first beat): one BUSY cycle minimum, then IDLE.
  - m_tready low for any duration: s_tready is low while the output register is full; no beat is lost or duplicated.
  - Only one requester active: it is re-granted every packet, with the IDLE bubble between packets.
- Wrap-around: the round-robin search wraps modulo N_SRC; last_grant=N_SRC-1 searches from 0.

Optional Feature:
- Macro: XDMA_ARB_STATS_EN.
- Defined: adds output ports stat_pkt_cnt (N_SRC*32) and stat_beat_cnt (N_SRC*32).
  - Per-source counters increment on each accepted input beat (beat) and on each accepted tlast beat (packet).
  - They wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package xdma_arb_pkg holds:
  - state enum (ARB_IDLE, ARB_BUSY);
  - function rr_pick(req, last) returning the grant index;
  - localparam defaults for AXIS_DATA_WIDTH / KEEP_WIDTH shared with the stream packers.
- One natural sub-module: xdma_axis_reg_slice, the one-entry output register with valid/ready. The arbiter instantiates it once.

Test Plan:
- Reset, then s_tvalid=2'b01, src0 sends a 3-beat packet with m_tready=1 -> m_tvalid rises 1 cycle after each handshake; m_tid=0; m_tlast on the 3rd beat; busy drops the cycle after the tlast handshake.
- Both sources continuously valid with 2-beat packets -> grants alternate 0,1,0,1; m_tid follows the same sequence; exactly 1 input bubble per packet boundary.
- src1 mid-packet, src1 s_tvalid low for 4 cycles while src0 is valid -> s_tready[0] stays 0; output idles 4 cycles; src1 packet completes before src0 is granted.
- m_tready held low 10 cycles during a src0 packet -> one beat is held on the output; s_tready[0]=0; after release all beats arrive in order with no duplicates.
- src_enable=2'b10 with both valid -> only src1 is served; clearing enable bit 1 mid-packet still completes the packet, then state stays IDLE.
- Assert reset mid-packet -> m_tvalid=0 and s_tready=0 immediately (asynchronous); after release, source 0 wins first arbitration. With XDMA_ARB_STATS_EN, all counters read 0.
